alu_exec: RTL and testbench
===========================

# alu_exec

Multi-cycle execute stage sitting directly downstream of the ALU decoder. It accepts the decoded operand pair and ALU select through a valid/ready handshake and computes the result. Shift operations are iterative, one bit per cycle; all other operations take one cycle. It holds the registered result and a zero flag until the writeback/branch logic downstream accepts it.

## Interface
Parameters:
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- clk  input  1  sole clock, rising-edge.
- rst  input  1  reset, asynchronous and active-high.
- in_valid  input  1  upstream presents op1/op2/alu_sel.
- in_ready  output  1  stage can accept this cycle.
- op1  input  32  operand 1; LUI: {12'b0, imm20}.
- op2  input  32  operand 2; SUB arrives as ADD with op2 already negated.
- alu_sel  input  5  function, `ALU_*` encodings from defines.vh.
- out_valid  output  1  result/zero valid.
- out_ready  input  1  downstream accepts result.
- result  output  32  registered result.
- zero  output  1  registered (result == 0); BEQ/BNE use it after XOR.
- busy  output  1  high while in SHIFT state.

## Operation
- FSM states: IDLE, SHIFT, DONE. Reset: state=IDLE, result=0, zero=1, out_valid=0, busy=0, internal accumulator=0, count=0.
- in_ready = (state==IDLE) | (state==DONE & out_ready). Accept = in_valid & in_ready.
- On accept, single-cycle ops are computed and registered, then state goes to DONE:
  - ADD: op1+op2, mod 2^32, no carry out.
  - XOR, OR, AND: bitwise.
  - SLT: {31'b0, signed(op1)<signed(op2)}.
  - SLTU: {31'b0, op1<op2}.
  - LUI: op1<<12, low 12 bits zero.
  - ALU_NONE or any unlisted code: result 0.
- On accept of SLL/SRL/SRA, amt = op2[4:0]; op2[31:5] is ignored.
  - amt==0: result=op1, go to DONE.
  - amt>0: acc=op1, count=amt, go to SHIFT.
- SHIFT, on each edge: acc shifts by 1, count decrements.
  - SLL fills 0. SRL fills 0. SRA fills acc[31].
  - At the edge where count==1: result=shifted acc, zero updated, go to DONE.
- DONE: out_valid=1; result and zero are held stable while out_ready=0.
  - out_ready=1 with no new accept: go to IDLE, out_valid=0.
  - out_ready=1 with simultaneous accept: the new op is processed as from IDLE in the same edge. out_valid stays 1 only if the new op is single-cycle or has amt==0; otherwise it drops to 0.
- Inputs are sampled only on accept. Changes to op1/op2/alu_sel during SHIFT have no effect.
- Asynchronous reset asserted mid-SHIFT or in DONE aborts the op immediately. All outputs return to reset values and the pending result is lost.

## Timing
- Single-cycle ops: accepted at edge E0, out_valid=1 from E0 to the next accept/handoff; latency 1 cycle.
- Shift with amt=k≥1: out_valid rises at edge E0+k; latency k+1 cycles; busy high for k cycles. in_ready=0 throughout.
- Max latency is 32 cycles (amt=31).
- Back-to-back single-cycle ops with out_ready held at 1 sustain 1 op/cycle.
- No combinational path from in_valid to out_valid. in_ready depends combinationally on out_ready only in DONE.

## Test plan
- Reset: assert rst asynchronously between edges → immediately out_valid=0, result=0, zero=1, in_ready=1, busy=0.
- ADD/SUB/LUI: op1=5, op2=-3 (0xFFFFFFFD), ALU_ADD → result 2 one cycle after accept. op1=0x12345, ALU_LUI → 0x12345000. op1=0xFFFFFFFF, op2=1, ADD → result 0, zero=1.
- SLT vs SLTU: op1=0xFFFFFFFF, op2=1 → SLT gives 1, SLTU gives 0. BEQ path: XOR 7,7 → zero=1.
- Shifts: SRA op1=0x80000000, op2=31 → result 0xFFFFFFFF, out_valid at accept+31 edges, busy high 31 cycles. SRL on the same inputs → 0x00000001. SLL op1=1, op2=0x25 → amt 5, result 0x20. SLL op2=0 → op1 after 1 cycle.
- Backpressure and back-to-back: hold out_ready=0 for 4 cycles in DONE → result stable, in_ready=0. Then out_ready=1 with in_valid=1 (AND 0xF0,0x3C) → handoff and accept on the same edge, next result 0x30.
- Reset mid-shift: SLL amt=20, assert rst after 5 shift cycles → immediate IDLE, outputs at reset values. A following ADD 1+1 → result 2.

Source files
------------

// File: rtl/alu_exec_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_exec_if
// Description : Handshake bundle between the ALU decoder, the execute stage
//               and the writeback/branch logic downstream of it.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_exec_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [4:0]      alu_sel;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zero;
    logic            busy;

    // Upstream decoder side plus downstream consumer: everything the stage does not drive.
    modport master (
        output in_valid, op1, op2, alu_sel, out_ready,
        input  in_ready, out_valid, result, zero, busy
    );

    modport slave (
        input  in_valid, op1, op2, alu_sel, out_ready,
        output in_ready, out_valid, result, zero, busy
    );
endinterface
`default_nettype wire

// File: rtl/alu_exec.sv
`default_nettype none
// ============================================================================
// Module      : alu_exec
// Description : Multi-cycle ALU execute stage. Shifts iterate one bit per
//               cycle; every other function completes in a single cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_exec #(
    parameter int XLEN = 32
) (
    input  wire          clk,
    input  wire          rst,
    alu_exec_if.slave    bus
);
    // ALU function encodings shared with the decoder.
    localparam logic [4:0] c_ALU_NONE = 5'd0;
    localparam logic [4:0] c_ALU_ADD  = 5'd1;
    localparam logic [4:0] c_ALU_SLL  = 5'd2;
    localparam logic [4:0] c_ALU_SLT  = 5'd3;
    localparam logic [4:0] c_ALU_SLTU = 5'd4;
    localparam logic [4:0] c_ALU_XOR  = 5'd5;
    localparam logic [4:0] c_ALU_SRL  = 5'd6;
    localparam logic [4:0] c_ALU_SRA  = 5'd7;
    localparam logic [4:0] c_ALU_OR   = 5'd8;
    localparam logic [4:0] c_ALU_AND  = 5'd9;
    localparam logic [4:0] c_ALU_LUI  = 5'd10;

    localparam int         c_AMT_W   = $clog2(XLEN);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_SHIFT   = 2'd1;
    localparam logic [1:0] c_DONE    = 2'd2;

    localparam logic [1:0] c_SH_LL   = 2'd0;
    localparam logic [1:0] c_SH_RL   = 2'd1;
    localparam logic [1:0] c_SH_RA   = 2'd2;

    logic [1:0]         r_state;
    logic [XLEN-1:0]    r_result;
    logic               r_zero;
    logic               r_out_valid;
    logic               r_busy;
    logic [XLEN-1:0]    r_acc;
    logic [c_AMT_W-1:0] r_count;
    logic [1:0]         r_shift_kind;

    logic               w_in_ready;
    logic               w_accept;
    logic               w_is_shift;
    logic [1:0]         w_shift_kind;
    logic [c_AMT_W-1:0] w_amt;
    logic [XLEN-1:0]    w_single;
    logic [XLEN-1:0]    w_acc_next;

    assign w_in_ready = (r_state == c_IDLE) || ((r_state == c_DONE) && bus.out_ready);
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_amt      = bus.op2[c_AMT_W-1:0];

    // Result of anything that finishes on the accepting edge, including
    // zero-amount shifts which simply pass op1 through.
    always_comb begin
        w_single     = '0;
        w_is_shift   = 1'b0;
        w_shift_kind = c_SH_LL;
        case (bus.alu_sel)
            c_ALU_ADD:  w_single = bus.op1 + bus.op2;
            c_ALU_XOR:  w_single = bus.op1 ^ bus.op2;
            c_ALU_OR:   w_single = bus.op1 | bus.op2;
            c_ALU_AND:  w_single = bus.op1 & bus.op2;
            c_ALU_SLT:  w_single = {{(XLEN-1){1'b0}}, ($signed(bus.op1) < $signed(bus.op2))};
            c_ALU_SLTU: w_single = {{(XLEN-1){1'b0}}, (bus.op1 < bus.op2)};
            c_ALU_LUI:  w_single = {bus.op1[XLEN-13:0], 12'b0};
            c_ALU_SLL: begin
                w_single     = bus.op1;
                w_is_shift   = 1'b1;
                w_shift_kind = c_SH_LL;
            end
            c_ALU_SRL: begin
                w_single     = bus.op1;
                w_is_shift   = 1'b1;
                w_shift_kind = c_SH_RL;
            end
            c_ALU_SRA: begin
                w_single     = bus.op1;
                w_is_shift   = 1'b1;
                w_shift_kind = c_SH_RA;
            end
            default:    w_single = '0;
        endcase
    end

    always_comb begin
        w_acc_next = r_acc;
        case (r_shift_kind)
            c_SH_LL: w_acc_next = {r_acc[XLEN-2:0], 1'b0};
            c_SH_RL: w_acc_next = {1'b0, r_acc[XLEN-1:1]};
            c_SH_RA: w_acc_next = {r_acc[XLEN-1], r_acc[XLEN-1:1]};
            default: w_acc_next = r_acc;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= c_IDLE;
            r_result     <= '0;
            r_zero       <= 1'b1;
            r_out_valid  <= 1'b0;
            r_busy       <= 1'b0;
            r_acc        <= '0;
            r_count      <= '0;
            r_shift_kind <= c_SH_LL;
        end else begin
            case (r_state)
                c_SHIFT: begin
                    r_acc   <= w_acc_next;
                    r_count <= r_count - 1'b1;
                    if (r_count == {{(c_AMT_W-1){1'b0}}, 1'b1}) begin
                        r_result    <= w_acc_next;
                        r_zero      <= (w_acc_next == '0);
                        r_out_valid <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= c_DONE;
                    end
                end
                default: begin
                    // IDLE and DONE share the accept path; a DONE handoff
                    // with a new op behaves exactly like an accept from IDLE.
                    if (w_accept) begin
                        if (w_is_shift && (w_amt != '0)) begin
                            r_acc        <= bus.op1;
                            r_count      <= w_amt;
                            r_shift_kind <= w_shift_kind;
                            r_busy       <= 1'b1;
                            r_out_valid  <= 1'b0;
                            r_state      <= c_SHIFT;
                        end else begin
                            r_result    <= w_single;
                            r_zero      <= (w_single == '0);
                            r_out_valid <= 1'b1;
                            r_state     <= c_DONE;
                        end
                    end else if ((r_state == c_DONE) && bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= c_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.result    = r_result;
    assign bus.zero      = r_zero;
    assign bus.busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_alu_exec.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_exec
// Description : Self-checking bench for alu_exec against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_exec;
    localparam logic [4:0] c_NONE = 5'd0;
    localparam logic [4:0] c_ADD  = 5'd1;
    localparam logic [4:0] c_SLL  = 5'd2;
    localparam logic [4:0] c_SLT  = 5'd3;
    localparam logic [4:0] c_SLTU = 5'd4;
    localparam logic [4:0] c_XOR  = 5'd5;
    localparam logic [4:0] c_SRL  = 5'd6;
    localparam logic [4:0] c_SRA  = 5'd7;
    localparam logic [4:0] c_OR   = 5'd8;
    localparam logic [4:0] c_AND  = 5'd9;
    localparam logic [4:0] c_LUI  = 5'd10;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    alu_exec_if #(.XLEN(32)) bus ();

    alu_exec #(.XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model_result(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b);
        case (sel)
            c_ADD:   return a + b;
            c_XOR:   return a ^ b;
            c_OR:    return a | b;
            c_AND:   return a & b;
            c_SLT:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            c_SLTU:  return (a < b) ? 32'd1 : 32'd0;
            c_LUI:   return a * 32'd4096;
            c_SLL:   return a << b[4:0];
            c_SRL:   return a >> b[4:0];
            c_SRA:   return $unsigned($signed(a) >>> b[4:0]);
            default: return 32'd0;
        endcase
    endfunction

    function automatic int model_latency(input logic [4:0] sel, input logic [31:0] b);
        if ((sel == c_SLL || sel == c_SRL || sel == c_SRA) && b[4:0] != 5'd0)
            return int'(b[4:0]) + 1;
        return 1;
    endfunction

    // Issue one op from IDLE, scramble inputs while it runs, and report
    // what the stage presented once out_valid rose.
    task automatic run_op(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] r, output logic z, output int lat, output int busy_cnt);
        bus.in_valid = 1'b1;
        bus.alu_sel  = sel;
        bus.op1      = a;
        bus.op2      = b;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat      = 1;
        busy_cnt = 0;
        while (!bus.out_valid && lat < 40) begin
            if (bus.busy) busy_cnt++;
            bus.op1     = $urandom;
            bus.op2     = $urandom;
            bus.alu_sel = 5'($urandom_range(0, 10));
            @(posedge clk); #1;
            lat++;
        end
        r = bus.result;
        z = bus.zero;
    endtask

    task automatic retire();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] r; logic z; int lat, bc;
        run_op(c_ADD, 32'd9, 32'd4, r, z, lat, bc);
        #3 rst = 1'b1;
        #1;
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        n_checks++; if (bus.result !== 32'd0) begin n_fail++; $display("FAIL reset_result: got %h expected 0", bus.result); end
        n_checks++; if (bus.zero !== 1'b1) begin n_fail++; $display("FAIL reset_zero: got %b expected 1", bus.zero); end
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_single_cycle();
        logic [4:0]  sels [7] = '{c_ADD, c_LUI, c_ADD, c_SLT, c_SLTU, c_XOR, c_NONE};
        logic [31:0] as   [7] = '{32'd5, 32'h12345, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd7, 32'hDEAD};
        logic [31:0] bs   [7] = '{32'hFFFFFFFD, 32'd0, 32'd1, 32'd1, 32'd1, 32'd7, 32'hBEEF};
        logic [31:0] exp  [7] = '{32'd2, 32'h12345000, 32'd0, 32'd1, 32'd0, 32'd0, 32'd0};
        logic [31:0] r; logic z; int lat, bc;
        for (int i = 0; i < 7; i++) begin
            run_op(sels[i], as[i], bs[i], r, z, lat, bc);
            n_checks++; if (r !== exp[i]) begin n_fail++; $display("FAIL single_result[%0d]: got %h expected %h", i, r, exp[i]); end
            n_checks++; if (z !== (exp[i] == 32'd0)) begin n_fail++; $display("FAIL single_zero[%0d]: got %b expected %b", i, z, exp[i] == 32'd0); end
            n_checks++; if (lat != 1) begin n_fail++; $display("FAIL single_latency[%0d]: got %0d expected 1", i, lat); end
            retire();
            n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL single_retire[%0d]: out_valid %b expected 0", i, bus.out_valid); end
        end
    endtask

    task automatic test_shifts();
        logic [4:0]  sels [4] = '{c_SRA, c_SRL, c_SLL, c_SLL};
        logic [31:0] as   [4] = '{32'h80000000, 32'h80000000, 32'd1, 32'h0000ABCD};
        logic [31:0] bs   [4] = '{32'd31, 32'd31, 32'h25, 32'd0};
        logic [31:0] exp  [4] = '{32'hFFFFFFFF, 32'h00000001, 32'h20, 32'h0000ABCD};
        int          elat [4] = '{32, 32, 6, 1};
        logic [31:0] r; logic z; int lat, bc;
        for (int i = 0; i < 4; i++) begin
            run_op(sels[i], as[i], bs[i], r, z, lat, bc);
            n_checks++; if (r !== exp[i]) begin n_fail++; $display("FAIL shift_result[%0d]: got %h expected %h", i, r, exp[i]); end
            n_checks++; if (lat != elat[i]) begin n_fail++; $display("FAIL shift_latency[%0d]: got %0d expected %0d", i, lat, elat[i]); end
            n_checks++; if (bc != elat[i] - 1) begin n_fail++; $display("FAIL shift_busy[%0d]: got %0d expected %0d", i, bc, elat[i] - 1); end
            retire();
        end
    endtask

    task automatic test_random();
        logic [31:0] r; logic z; int lat, bc;
        for (int i = 0; i < 40; i++) begin
            logic [4:0]  sel = (i % 8 == 7) ? 5'($urandom_range(11, 31)) : 5'($urandom_range(0, 10));
            logic [31:0] a   = $urandom;
            logic [31:0] b   = $urandom;
            logic [31:0] e;
            if (i % 5 == 0) a = 32'd0;
            e = model_result(sel, a, b);
            run_op(sel, a, b, r, z, lat, bc);
            n_checks++; if (r !== e) begin n_fail++; $display("FAIL rand_result[%0d] sel=%0d a=%h b=%h: got %h expected %h", i, sel, a, b, r, e); end
            n_checks++; if (z !== (e == 32'd0)) begin n_fail++; $display("FAIL rand_zero[%0d]: got %b expected %b", i, z, e == 32'd0); end
            n_checks++; if (lat != model_latency(sel, b)) begin n_fail++; $display("FAIL rand_latency[%0d]: got %0d expected %0d", i, lat, model_latency(sel, b)); end
            n_checks++; if (bc != model_latency(sel, b) - 1) begin n_fail++; $display("FAIL rand_busy[%0d]: got %0d expected %0d", i, bc, model_latency(sel, b) - 1); end
            retire();
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] r; logic z; int lat, bc;
        run_op(c_ADD, 32'd100, 32'd23, r, z, lat, bc);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            n_checks++; if (bus.result !== 32'd123 || bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL hold_result[%0d]: got %h/%b expected 0000007b/1", i, bus.result, bus.out_valid); end
            n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL hold_in_ready[%0d]: got %b expected 0", i, bus.in_ready); end
        end
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.alu_sel   = c_AND;
        bus.op1       = 32'hF0;
        bus.op2       = 32'h3C;
        #1;
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL handoff_in_ready: got %b expected 1", bus.in_ready); end
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        n_checks++; if (bus.result !== 32'h30 || bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL handoff_result: got %h/%b expected 00000030/1", bus.result, bus.out_valid); end
        retire();
    endtask

    task automatic test_back_to_back();
        logic [31:0] e;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            logic [4:0] pick [7] = '{c_ADD, c_XOR, c_OR, c_AND, c_SLT, c_SLTU, c_LUI};
            bus.in_valid = 1'b1;
            bus.alu_sel  = pick[$urandom_range(0, 6)];
            bus.op1      = $urandom;
            bus.op2      = $urandom;
            e = model_result(bus.alu_sel, bus.op1, bus.op2);
            @(posedge clk); #1;
            n_checks++; if (bus.out_valid !== 1'b1 || bus.result !== e) begin n_fail++; $display("FAIL b2b[%0d]: got %h/%b expected %h/1", i, bus.result, bus.out_valid, e); end
        end
        // A multi-cycle shift taken on a handoff edge drops out_valid.
        bus.alu_sel = c_SRL;
        bus.op1     = 32'h80;
        bus.op2     = 32'd3;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        n_checks++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL b2b_shift_start: got valid=%b busy=%b expected 0/1", bus.out_valid, bus.busy); end
        repeat (3) begin @(posedge clk); #1; end
        n_checks++; if (bus.out_valid !== 1'b1 || bus.result !== 32'h10) begin n_fail++; $display("FAIL b2b_shift_result: got %h/%b expected 00000010/1", bus.result, bus.out_valid); end
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: out_valid %b expected 0", bus.out_valid); end
    endtask

    task automatic test_reset_mid_shift();
        logic [31:0] r; logic z; int lat, bc;
        bus.in_valid = 1'b1;
        bus.alu_sel  = c_SLL;
        bus.op1      = 32'h1;
        bus.op2      = 32'd20;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL midshift_busy: got %b expected 1", bus.busy); end
        #2 rst = 1'b1;
        #1;
        n_checks++; if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL midshift_ctrl: busy=%b valid=%b ready=%b expected 0/0/1", bus.busy, bus.out_valid, bus.in_ready); end
        n_checks++; if (bus.result !== 32'd0 || bus.zero !== 1'b1) begin n_fail++; $display("FAIL midshift_data: result=%h zero=%b expected 0/1", bus.result, bus.zero); end
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        run_op(c_ADD, 32'd1, 32'd1, r, z, lat, bc);
        n_checks++; if (r !== 32'd2 || lat != 1) begin n_fail++; $display("FAIL post_reset_add: got %h lat %0d expected 2 lat 1", r, lat); end
        retire();
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.op1       = '0;
        bus.op2       = '0;
        bus.alu_sel   = c_NONE;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_single_cycle();
        test_shifts();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_shift();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
